// File: rtl/muldiv_ctrl_if.sv
// Issue/result bundle between the EX/ID stages and the multiply/divide
// sequencer. The CPU side uses the master modport, the sequencer the slave.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Cancel;
  logic             HiWr;
  logic             LoWr;
  logic [WIDTH-1:0] WrData;
  logic             UseHiLo_ID;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;
  logic             Done;
  logic             MulDiv_Stall;

  modport master (
    output Start, Op, SrcA, SrcB, Cancel, HiWr, LoWr, WrData, UseHiLo_ID,
    input  HI, LO, Busy, Done, MulDiv_Stall
  );

  modport slave (
    input  Start, Op, SrcA, SrcB, Cancel, HiWr, LoWr, WrData, UseHiLo_ID,
    output HI, LO, Busy, Done, MulDiv_Stall
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative mult/multu/div/divu sequencer owning the HI/LO registers.
// One multiplier/quotient bit per CALC cycle, sign fix-up in SIGN.
// Optional feature: define MULDIV_EARLY_EXIT_EN to skip CALC for
// zero operands (multiply by zero, or zero dividend with non-zero divisor).
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          CLK,
  input logic          RST_n,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   accReg;      // mult: {partial sum, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]     operandReg;  // mult: |multiplicand|; div: |divisor|
  logic [WIDTH-1:0]     origA;       // dividend as issued, for divide-by-zero HI
  logic                 signA;
  logic                 signB;
  logic                 isDiv;
  logic                 divZero;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     hiReg;
  logic [WIDTH-1:0]     loReg;
  logic                 busyReg;
  logic                 doneReg;

  // Conditional two's-complement negation, operand width.
  function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  // Conditional two's-complement negation, product width.
  function automatic logic [2*WIDTH-1:0] condNeg2(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  // Operand conditioning at issue: signed ops take magnitudes plus sign flags.
  logic             opSigned;
  logic             loadSignA;
  logic             loadSignB;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;

  assign opSigned  = ~bus.Op[0];
  assign loadSignA = opSigned & bus.SrcA[WIDTH-1];
  assign loadSignB = opSigned & bus.SrcB[WIDTH-1];
  assign absA      = condNeg(bus.SrcA, loadSignA);
  assign absB      = condNeg(bus.SrcB, loadSignB);

`ifdef MULDIV_EARLY_EXIT_EN
  logic earlyZero;
  assign earlyZero = bus.Op[1] ? ((bus.SrcA == '0) && (bus.SrcB != '0))
                               : ((bus.SrcA == '0) || (bus.SrcB == '0));
`endif

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  logic [WIDTH:0]       mulSum;
  logic [WIDTH:0]       divUpper;
  logic [WIDTH-1:0]     remTrial;
  logic                 divGeq;
  logic [2*WIDTH-1:0]   accNext;

  always_comb begin
    mulSum   = {1'b0, accReg[2*WIDTH-1:WIDTH]} + (accReg[0] ? {1'b0, operandReg} : '0);
    divUpper = accReg[2*WIDTH-1:WIDTH-1];
    divGeq   = (divUpper >= {1'b0, operandReg});
    remTrial = divUpper[WIDTH-1:0] - operandReg;
    accNext  = '0;
    if (!isDiv)
      accNext = {mulSum, accReg[WIDTH-1:1]};
    else if (divGeq)
      accNext = {remTrial, accReg[WIDTH-2:0], 1'b1};
    else
      accNext = {divUpper[WIDTH-1:0], accReg[WIDTH-2:0], 1'b0};
  end

  // Sign fix-up and divide-by-zero substitution applied in SIGN.
  logic [2*WIDTH-1:0] prodFinal;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

  always_comb begin
    prodFinal = condNeg2(accReg, signA ^ signB);
    resHi     = prodFinal[2*WIDTH-1:WIDTH];
    resLo     = prodFinal[WIDTH-1:0];
    if (isDiv) begin
      if (divZero) begin
        resLo = '1;
        resHi = origA;
      end else begin
        resLo = condNeg(accReg[WIDTH-1:0], signA ^ signB);
        resHi = condNeg(accReg[2*WIDTH-1:WIDTH], signA);
      end
    end
  end

  // Sequencer FSM: issue, iterate, fix up signs, and service mthi/mtlo in IDLE.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      accReg     <= '0;
      operandReg <= '0;
      origA      <= '0;
      signA      <= 1'b0;
      signB      <= 1'b0;
      isDiv      <= 1'b0;
      divZero    <= 1'b0;
      cnt        <= '0;
      hiReg      <= '0;
      loReg      <= '0;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
    end else if (bus.Cancel) begin
      state   <= IDLE;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.Start) begin
            signA      <= loadSignA;
            signB      <= loadSignB;
            isDiv      <= bus.Op[1];
            divZero    <= bus.Op[1] && (bus.SrcB == '0);
            origA      <= bus.SrcA;
            operandReg <= bus.Op[1] ? absB : absA;
            accReg     <= bus.Op[1] ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
            cnt        <= '0;
            busyReg    <= 1'b1;
`ifdef MULDIV_EARLY_EXIT_EN
            if (earlyZero) begin
              accReg <= '0;
              state  <= SIGN;
            end else begin
              state  <= CALC;
            end
`else
            state      <= CALC;
`endif
          end else begin
            if (bus.HiWr) hiReg <= bus.WrData;
            if (bus.LoWr) loReg <= bus.WrData;
          end
        end
        CALC: begin
          accReg <= accNext;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          hiReg   <= resHi;
          loReg   <= resLo;
          doneReg <= 1'b1;
          busyReg <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HI           = hiReg;
  assign bus.LO           = loReg;
  assign bus.Busy         = busyReg;
  assign bus.Done         = doneReg;
  assign bus.MulDiv_Stall = bus.UseHiLo_ID & (busyReg | bus.Start);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed testbench for muldiv_ctrl: arithmetic results, latency, stall,
// mthi/mtlo, cancel and asynchronous reset behaviour.
module tb_muldiv_ctrl;

  logic CLK;
  logic RST_n;
  int   nTests;
  int   nFail;

  muldiv_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required completion");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after the Done cycle.
  task automatic doOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] expHi,
                      input logic [31:0] expLo, input int expLat);
    int lat;
    int busyCnt;
    lat = 0;
    busyCnt = 0;
    bus.Op = op;
    bus.SrcA = a;
    bus.SrcB = b;
    bus.Start = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (bus.Done) begin
        lat = n;
        break;
      end
      if (bus.Busy) busyCnt++;
      @(posedge CLK); #1;
    end
    checkVal({tag, ".latency"}, lat, expLat);
    checkVal({tag, ".busyCycles"}, busyCnt, expLat - 1);
    checkVal({tag, ".HI"}, bus.HI, expHi);
    checkVal({tag, ".LO"}, bus.LO, expLo);
    checkVal({tag, ".busyInDone"}, bus.Busy, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    checkVal({tag, ".donePulse"}, bus.Done, 0);
    @(posedge CLK); #1;
  endtask

  task automatic writeHiLo(input logic [31:0] hiVal, input logic [31:0] loVal);
    bus.HiWr = 1'b1;
    bus.WrData = hiVal;
    @(posedge CLK); #1;
    bus.HiWr = 1'b0;
    bus.LoWr = 1'b1;
    bus.WrData = loVal;
    @(posedge CLK); #1;
    bus.LoWr = 1'b0;
  endtask

  initial begin
    int stallCnt;
    int doneSeen;
    nTests = 0;
    nFail = 0;
    bus.Start = 1'b0;
    bus.Op = 2'b00;
    bus.SrcA = '0;
    bus.SrcB = '0;
    bus.Cancel = 1'b0;
    bus.HiWr = 1'b0;
    bus.LoWr = 1'b0;
    bus.WrData = '0;
    bus.UseHiLo_ID = 1'b0;
    RST_n = 1'b1;

    // Reset state
    #3 RST_n = 1'b0;
    repeat (2) @(negedge CLK);
    checkVal("reset.HI", bus.HI, 0);
    checkVal("reset.LO", bus.LO, 0);
    checkVal("reset.Busy", bus.Busy, 0);
    checkVal("reset.Done", bus.Done, 0);
    RST_n = 1'b1;
    @(posedge CLK); #1;

    // Arithmetic vectors
    doOp("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 34);
    doOp("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 34);
    doOp("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34);
    doOp("div_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 34);
    doOp("div_m7_0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 34);
    doOp("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 34);
    doOp("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
    doOp("mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 34);
    doOp("div_100_m7", 2'b10, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 34);
`ifdef MULDIV_EARLY_EXIT_EN
    doOp("multu_0x9", 2'b01, 32'd0, 32'd9, 32'd0, 32'd0, 2);
`else
    doOp("multu_0x9", 2'b01, 32'd0, 32'd9, 32'd0, 32'd0, 34);
`endif

    // Stall window and mthi ignored while busy
    bus.Op = 2'b00;
    bus.SrcA = 32'd3;
    bus.SrcB = 32'd5;
    bus.Start = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    stallCnt = 0;
    for (int c = 1; c <= 34; c++) begin
      bus.UseHiLo_ID = (c >= 3);
      bus.HiWr = (c == 5);
      bus.WrData = 32'h1234;
      @(negedge CLK);
      if (c >= 3 && c <= 33 && bus.MulDiv_Stall) stallCnt++;
      if (c == 34) begin
        checkVal("stall.cycles3to33", stallCnt, 31);
        checkVal("stall.doneCycle", bus.MulDiv_Stall, 0);
        checkVal("stall.done", bus.Done, 1);
        checkVal("stall.HI", bus.HI, 0);
        checkVal("stall.LO", bus.LO, 15);
      end else begin
        @(posedge CLK); #1;
      end
    end
    bus.UseHiLo_ID = 1'b0;
    bus.HiWr = 1'b0;
    @(posedge CLK); #1;

    // mthi/mtlo preload
    writeHiLo(32'hAAAA, 32'h5555);
    @(negedge CLK);
    checkVal("mthi.HI", bus.HI, 32'hAAAA);
    checkVal("mtlo.LO", bus.LO, 32'h5555);
    @(posedge CLK); #1;

    // Start beats a simultaneous mthi; cancel right away keeps HI/LO
    bus.Op = 2'b00;
    bus.SrcA = 32'd9;
    bus.SrcB = 32'd9;
    bus.Start = 1'b1;
    bus.HiWr = 1'b1;
    bus.WrData = 32'hDEAD;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    bus.HiWr = 1'b0;
    bus.Cancel = 1'b1;
    @(posedge CLK); #1;
    bus.Cancel = 1'b0;
    @(negedge CLK);
    checkVal("startWins.HI", bus.HI, 32'hAAAA);
    checkVal("startWins.Busy", bus.Busy, 0);
    @(posedge CLK); #1;

    // Cancel div in cycle 10
    bus.Op = 2'b10;
    bus.SrcA = 32'd1000;
    bus.SrcB = 32'd3;
    bus.Start = 1'b1;
    bus.UseHiLo_ID = 1'b1;
    @(negedge CLK);
    checkVal("stall.startCycle", bus.MulDiv_Stall, 1);
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    bus.UseHiLo_ID = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    checkVal("cancel.busyBefore", bus.Busy, 1);
    bus.Cancel = 1'b1;
    @(posedge CLK); #1;
    bus.Cancel = 1'b0;
    @(negedge CLK);
    checkVal("cancel.busyAfter", bus.Busy, 0);
    doneSeen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (bus.Done) doneSeen++;
    end
    checkVal("cancel.noDone", doneSeen, 0);
    checkVal("cancel.HI", bus.HI, 32'hAAAA);
    checkVal("cancel.LO", bus.LO, 32'h5555);
    @(posedge CLK); #1;

    // Asynchronous reset mid-operation in cycle 12
    bus.Op = 2'b01;
    bus.SrcA = 32'h12345678;
    bus.SrcB = 32'h10;
    bus.Start = 1'b1;
    @(posedge CLK); #1;
    bus.Start = 1'b0;
    repeat (11) @(posedge CLK);
    #1;
    checkVal("rst.busyBefore", bus.Busy, 1);
    RST_n = 1'b0;
    #1;
    checkVal("rst.HI", bus.HI, 0);
    checkVal("rst.LO", bus.LO, 0);
    checkVal("rst.Busy", bus.Busy, 0);
    @(negedge CLK);
    RST_n = 1'b1;
    @(posedge CLK); #1;
    doOp("multu_after_rst", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 34);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
